// File: rtl/snn_event_pkg.sv
// snn_event_pkg: event widths, upstream field offsets and bridge FSM states shared by the event-path blocks.
package snn_event_pkg;

  typedef enum logic [1:0] {RUN, FLUSH, MARKER} bridge_state_t;

  localparam int SPIKES_LSB = 0;

  function automatic int in_event_width(input int bpc, input int ch);
    return 1 + 2 * bpc + ch;
  endfunction

  function automatic int pooled_event_width(input int bpc, input int ch);
    return 2 * (bpc - 1) + ch + 1;
  endfunction

  // Offsets are given for a {timestep, x, y, spikes} word with cbits-wide coordinates.
  function automatic int y_lsb(input int ch);
    return ch;
  endfunction

  function automatic int x_lsb(input int cbits, input int ch);
    return ch + cbits;
  endfunction

  function automatic int ts_bit(input int cbits, input int ch);
    return ch + 2 * cbits;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: first-word-fall-through register FIFO; a pop in the same cycle lets a push into a full buffer through.
module event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_q + AW'(do_pop);
      wr_q  <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;

endmodule

// File: rtl/conv_event_bridge.sv
// conv_event_bridge: buffers pooled conv events, merges same-coordinate spikes per timestep,
// drops empty events and widens coordinates for the next layer's input port.
module conv_event_bridge
  import snn_event_pkg::*;
#(
  parameter int OUT_CHANNELS        = 4,
  parameter int BITS_PER_COORDINATE = 7,
  parameter int FIFO_DEPTH          = 16,
  parameter int STAT_WIDTH          = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  enable,
  input  logic                                                  up_write_enable,
  input  logic [pooled_event_width(BITS_PER_COORDINATE, OUT_CHANNELS)-1:0] up_data,
  output logic                                                  up_full_next,
  output logic                                                  dn_write_enable,
  output logic [in_event_width(BITS_PER_COORDINATE, OUT_CHANNELS)-1:0]     dn_data,
  input  logic                                                  dn_full_next,
  output logic                                                  overflow,
  output logic                                                  busy,
  output logic [STAT_WIDTH-1:0]                                 stat_forwarded,
  output logic [STAT_WIDTH-1:0]                                 stat_merged,
  output logic [STAT_WIDTH-1:0]                                 stat_dropped
);
  localparam int UW = pooled_event_width(BITS_PER_COORDINATE, OUT_CHANNELS);
  localparam int DW = in_event_width(BITS_PER_COORDINATE, OUT_CHANNELS);
  localparam int CB = BITS_PER_COORDINATE - 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  bridge_state_t           state_q, state_d;
  logic [UW-1:0]           head;
  logic [CW-1:0]           count;
  logic                    full, empty;
  logic                    h_ts, same_xy;
  logic [CB-1:0]           h_x, h_y;
  logic [OUT_CHANNELS-1:0] h_s;
  logic                    hold_v_q;
  logic [CB-1:0]           hold_x_q, hold_y_q;
  logic [OUT_CHANNELS-1:0] hold_s_q;
  logic                    pop, load, merge, clr, emit, drop;
  logic                    overflow_q;
  logic [STAT_WIDTH-1:0]   fwd_q, mrg_q, drp_q;

  event_fifo #(.W(UW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (up_write_enable),
    .pop_i   (pop),
    .data_i  (up_data),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign h_ts    = head[ts_bit(CB, OUT_CHANNELS)];
  assign h_x     = head[x_lsb(CB, OUT_CHANNELS) +: CB];
  assign h_y     = head[y_lsb(OUT_CHANNELS) +: CB];
  assign h_s     = head[SPIKES_LSB +: OUT_CHANNELS];
  assign same_xy = h_x == hold_x_q && h_y == hold_y_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    merge   = 1'b0;
    clr     = 1'b0;
    emit    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      RUN: if (enable && !empty) begin
        if (h_ts) state_d = hold_v_q ? FLUSH : MARKER;
        else if (h_s == '0) {pop, drop} = 2'b11;
        else if (!hold_v_q) {pop, load} = 2'b11;
        else if (same_xy) {pop, merge} = 2'b11;
        else if (!dn_full_next) {pop, load, emit} = 3'b111;
      end
      FLUSH: if (enable && !dn_full_next) begin
        {emit, clr} = 2'b11;
        state_d = MARKER;
      end
      MARKER: if (enable && !dn_full_next) begin
        {emit, pop} = 2'b11;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= RUN;
      hold_v_q   <= 1'b0;
      hold_x_q   <= '0;
      hold_y_q   <= '0;
      hold_s_q   <= '0;
      overflow_q <= 1'b0;
      fwd_q      <= '0;
      mrg_q      <= '0;
      drp_q      <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        hold_v_q <= 1'b1;
        hold_x_q <= h_x;
        hold_y_q <= h_y;
        hold_s_q <= h_s;
      end else if (merge) hold_s_q <= hold_s_q | h_s;
      else if (clr) hold_v_q <= 1'b0;
      overflow_q <= overflow_q | (up_write_enable && full && !pop);
      if (emit && fwd_q != '1) fwd_q <= fwd_q + STAT_WIDTH'(1);
      if (merge && mrg_q != '1) mrg_q <= mrg_q + STAT_WIDTH'(1);
      if (drop && drp_q != '1) drp_q <= drp_q + STAT_WIDTH'(1);
    end

  // In MARKER the head is the marker itself, so the constant marker word is emitted.
  assign dn_data         = state_q == MARKER ? {1'b1, {(DW-1){1'b0}}}
                                             : {1'b0, 1'b0, hold_x_q, 1'b0, hold_y_q, hold_s_q};
  assign dn_write_enable = emit;
  assign up_full_next    = count >= CW'(FIFO_DEPTH - 1);
  assign overflow        = overflow_q;
  assign busy            = !empty || hold_v_q || state_q != RUN;
  assign stat_forwarded  = fwd_q;
  assign stat_merged     = mrg_q;
  assign stat_dropped    = drp_q;

endmodule

// File: tb/tb_conv_event_bridge.sv
// tb_conv_event_bridge: scoreboard bench; a stream-level model predicts every downstream write and the counters.
module tb_conv_event_bridge;
  localparam int CH = 4, BPC = 7, D = 16, SW = 16;
  localparam int UW = 2 * (BPC - 1) + CH + 1;
  localparam int DW = 1 + 2 * BPC + CH;

  logic          clk = 0, rst_n = 0, enable = 0, up_write_enable = 0, dn_full_next = 0;
  logic [UW-1:0] up_data = '0;
  logic [DW-1:0] dn_data;
  logic          up_full_next, dn_write_enable, overflow, busy;
  logic [SW-1:0] stat_forwarded, stat_merged, stat_dropped;

  int total = 0, bad = 0, writes = 0;
  logic [DW-1:0] exp_q[$];
  logic          mh_v = 0;
  logic [5:0]    mh_x, mh_y;
  logic [3:0]    mh_s;
  int            m_fwd = 0, m_mrg = 0, m_drp = 0;

  conv_event_bridge #(.OUT_CHANNELS(CH), .BITS_PER_COORDINATE(BPC), .FIFO_DEPTH(D), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_write_enable(up_write_enable), .up_data(up_data),
    .up_full_next(up_full_next), .dn_write_enable(dn_write_enable), .dn_data(dn_data),
    .dn_full_next(dn_full_next), .overflow(overflow), .busy(busy), .stat_forwarded(stat_forwarded),
    .stat_merged(stat_merged), .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  // Timestep-level behaviour: output sequence only depends on the accepted event stream.
  task automatic model_ev(input logic ts, input logic [5:0] x, input logic [5:0] y, input logic [3:0] s);
    if (ts) begin
      if (mh_v) begin exp_q.push_back({2'b00, mh_x, 1'b0, mh_y, mh_s}); m_fwd++; end
      exp_q.push_back({1'b1, 18'd0});
      m_fwd++;
      mh_v = 0;
    end else if (s == 0) m_drp++;
    else if (mh_v && mh_x == x && mh_y == y) begin mh_s = mh_s | s; m_mrg++; end
    else begin
      if (mh_v) begin exp_q.push_back({2'b00, mh_x, 1'b0, mh_y, mh_s}); m_fwd++; end
      mh_v = 1; mh_x = x; mh_y = y; mh_s = s;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mh_v = 0; m_fwd = 0; m_mrg = 0; m_drp = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ts, input logic [5:0] x, input logic [5:0] y, input logic [3:0] s, input bit mdl);
    up_write_enable = 1;
    up_data = {ts, x, y, s};
    if (mdl) model_ev(ts, x, y, s);
    tick();
    up_write_enable = 0;
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 500 && (exp_q.size() != 0 || busy); i++) tick();
    chk({n, "_drained"}, {31'd0, exp_q.size() == 0 && !busy}, 32'd1);
    chk({n, "_fwd"}, 32'(stat_forwarded), 32'(m_fwd));
    chk({n, "_merged"}, 32'(stat_merged), 32'(m_mrg));
    chk({n, "_dropped"}, 32'(stat_dropped), 32'(m_drp));
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_we"}, {31'd0, dn_write_enable}, 0);
    chk({n, "_data"}, 32'(dn_data), 0);
    chk({n, "_flags"}, {28'd0, up_full_next, overflow, busy, 1'b0}, 0);
    chk({n, "_stats"}, 32'(stat_forwarded) | 32'(stat_merged) | 32'(stat_dropped), 0);
  endtask

  always @(negedge clk)
    if (rst_n && dn_write_enable) begin
      writes++;
      chk("we_vs_full", {31'd0, dn_full_next}, 0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write got=%0h want=none", dn_data);
      end else chk("dn_data", 32'(dn_data), 32'(exp_q.pop_front()));
    end

  initial begin
    int w0, r;
    logic [5:0] x, y;
    #3 chk_zero("reset");
    tick();
    rst_n = 1;
    enable = 1;
    // merge
    push(0, 3, 2, 4'b0001, 1); push(0, 3, 2, 4'b0100, 1); push(1, 0, 0, 0, 1);
    drain("merge");
    // distinct coordinates and drop
    model_reset();
    rst_n = 0; #1 rst_n = 1;
    push(0, 1, 1, 4'b0010, 1); push(0, 1, 1, 4'b0000, 1); push(0, 5, 6, 4'b1000, 1); push(1, 0, 0, 0, 1);
    drain("distinct");
    // backpressure
    dn_full_next = 1;
    w0 = writes;
    push(0, 1, 1, 4'b0010, 1); push(0, 1, 1, 4'b0000, 1); push(0, 5, 6, 4'b1000, 1); push(1, 0, 0, 0, 1);
    repeat (20) tick();
    chk("stall_writes", 32'(writes - w0), 0);
    dn_full_next = 0;
    drain("backpressure");
    // widening
    push(0, 63, 63, 4'b1111, 1); push(1, 0, 0, 0, 1);
    drain("widen");
    // overflow with pops disabled
    enable = 0;
    for (int i = 0; i < 17; i++) begin
      push(0, 6'(i), 1, 4'b0001, i < 16);
      chk($sformatf("full_next_%0d", i + 1), {31'd0, up_full_next}, {31'd0, i + 1 >= 15});
      chk($sformatf("overflow_%0d", i + 1), {31'd0, overflow}, {31'd0, i == 16});
    end
    enable = 1;
    for (int i = 0; i < 50 && up_full_next; i++) tick();
    push(1, 0, 0, 0, 1);
    drain("overflow");
    // reset while flushing
    dn_full_next = 1;
    push(0, 2, 2, 4'b0001, 1); push(1, 0, 0, 0, 1);
    repeat (5) tick();
    dn_full_next = 0;
    #1 chk("flush_we", {31'd0, dn_write_enable}, 1);
    #1 rst_n = 0;
    #1 chk_zero("midreset");
    model_reset();
    tick();
    rst_n = 1;
    chk("busy_after_reset", {31'd0, busy}, 0);
    push(1, 0, 0, 0, 1);
    drain("after_reset");
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      enable = $urandom_range(9) != 0;
      dn_full_next = $urandom_range(9) < 3;
      up_write_enable = 0;
      if (!up_full_next && $urandom_range(9) < 6) begin
        r = $urandom_range(99);
        x = r < 80 ? 6'($urandom_range(1)) : 6'($urandom_range(63));
        y = r < 80 ? 6'($urandom_range(1)) : 6'($urandom_range(63));
        up_write_enable = 1;
        up_data = {r < 10, x, y, 4'($urandom_range(15))};
        model_ev(up_data[16], up_data[15:10], up_data[9:4], up_data[3:0]);
      end
      tick();
    end
    up_write_enable = 0;
    enable = 1;
    dn_full_next = 0;
    for (int i = 0; i < 50 && up_full_next; i++) tick();
    push(1, 0, 0, 0, 1);
    drain("random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
